// File: rtl/dff_write_arbiter_if.sv
// Write-port bundle between NUM_REQ requesters and the shared register's arbiter.
interface dff_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int OW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         q;
  logic [OW-1:0]            q_owner;
  logic                     q_valid;
  logic                     busy;

  // requester side
  modport master (output req, wdata, input gnt, q, q_owner, q_valid, busy);
  // arbiter side
  modport slave  (input req, wdata, output gnt, q, q_owner, q_valid, busy);
endinterface

// File: rtl/dff_write_arbiter.sv
// Round-robin write controller for one shared WIDTH-bit register.
// IDLE picks a requester, WRITE pulses its grant and loads its data,
// HOLD keeps the value stable for HOLD_CYCLES before re-arbitrating.

// Per-requester grant decode: a lane fires only when it is the selected
// index, the FSM is in WRITE, and the requester is still asking.
module dff_write_arbiter_lane #(
  parameter int IDX = 0,
  parameter int OW  = 2
) (
  input  logic [OW-1:0] sel,
  input  logic          in_write,
  input  logic          req,
  output logic          gnt
);
  assign gnt = in_write & req & (sel == OW'(IDX));
endmodule

module dff_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic              clk,
  input logic              reset_n,
  dff_write_arbiter_if.slave bus
);
  localparam int OW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = ($clog2(HOLD_CYCLES) > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [OW-1:0] LAST     = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD} state_t;

  state_t                          state, state_nxt;
  logic [OW-1:0]                   sel, ptr, pick;
  logic                            found;
  logic [CW-1:0]                   cnt;
  logic [WIDTH-1:0]                q;
  logic [OW-1:0]                   q_owner;
  logic                            q_valid;
  logic                            req_sel, write_fire, in_write;
  logic [NUM_REQ-1:0]              gnt_vec;
  logic [NUM_REQ-1:0][WIDTH-1:0]   wd;
  int                              idx;

  assign wd         = bus.wdata;
  assign req_sel    = bus.req[sel];
  assign write_fire = (state == WRITE) && req_sel;

  // Round-robin search starting at ptr; wrap done by subtraction so
  // non-power-of-two NUM_REQ works.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: a dropped request in WRITE aborts straight back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (found) state_nxt = WRITE;
      WRITE: begin
        if (!req_sel)              state_nxt = IDLE;
        else if (HOLD_CYCLES == 0) state_nxt = IDLE;
        else                       state_nxt = HOLD;
      end
      HOLD:  if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch winner in IDLE, commit the write, run the hold counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      q       <= '0;
      q_owner <= '0;
      q_valid <= 1'b0;
    end else begin
      if (state == IDLE && found) sel <= pick;
      if (write_fire) begin
        q       <= wd[sel];
        q_owner <= sel;
        q_valid <= 1'b1;
        ptr     <= (sel == LAST) ? '0 : sel + 1'b1;
        cnt     <= CNT_LOAD;
      end else if (state == HOLD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Outputs: grant only in WRITE, suppressed in a reset cycle.
  always_comb begin
    in_write = (state == WRITE) && reset_n;
    bus.busy = (state != IDLE);
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    dff_write_arbiter_lane #(.IDX(i), .OW(OW)) u_lane (
      .sel      (sel),
      .in_write (in_write),
      .req      (bus.req[i]),
      .gnt      (gnt_vec[i])
    );
  end

  assign bus.gnt     = gnt_vec;
  assign bus.q       = q;
  assign bus.q_owner = q_owner;
  assign bus.q_valid = q_valid;
endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter: HOLD_CYCLES=2 main instance plus
// a HOLD_CYCLES=0 instance for the back-to-back grant case.
module tb_dff_write_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dff_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();
  dff_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus0 ();

  dff_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  dff_write_arbiter #(.NUM_REQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));

  typedef struct { int idx; logic [7:0] data; } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] one = 4'b0001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d);
    exp_t e;
    e.idx = i; e.data = d;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a grant on the main instance, compare against the
  // scoreboard head, then check the register on the following cycle.
  task automatic expect_grant(input string tag, input int lat);
    exp_t e;
    int   waited = 0;
    bit   seen = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.gnt != 4'b0) begin waited = i; seen = 1'b1; break; end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(waited), 32'(lat));
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'(one << e.idx));
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.gnt), 32'd0);
      chk({tag, "_q"}, 32'(bus.q), 32'(e.data));
      chk({tag, "_own"}, 32'(bus.q_owner), 32'(e.idx));
      chk({tag, "_vld"}, 32'(bus.q_valid), 32'd1);
    end
  endtask

  task automatic set_wd(input int i, input logic [7:0] v);
    bus.wdata[i*8 +: 8] = v;
  endtask

  initial begin
    logic [7:0] d0 [4];
    d0 = '{8'h12, 8'h34, 8'h56, 8'h78};
    // 1: reset held two edges with all requests high
    reset_n = 1'b0; bus.req = 4'hF; bus.wdata = '0;
    bus0.req = 4'h0; bus0.wdata = {d0[3], d0[2], d0[1], d0[0]};
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_vld", 32'(bus.q_valid), 32'd0);
    chk("rst_own", 32'(bus.q_owner), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // 2: single requester
    reset_n = 1'b1; bus.req = 4'b0010; set_wd(1, 8'h55);
    push(1, 8'h55);
    expect_grant("single", 1);
    bus.req = 4'b0;
    @(negedge clk);
    chk("single_hold2_busy", 32'(bus.busy), 32'd1);
    chk("single_hold2_gnt", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    chk("single_idle_busy", 32'(bus.busy), 32'd0);
    chk("single_q_kept", 32'(bus.q), 32'h55);

    // 3: all requesting, rotation from reset
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    set_wd(0, 8'hAA); set_wd(1, 8'h55); set_wd(2, 8'h0F); set_wd(3, 8'hF0);
    bus.req = 4'hF;
    push(0, 8'hAA); push(1, 8'h55); push(2, 8'h0F); push(3, 8'hF0); push(0, 8'hAA);
    expect_grant("rr0", 1);
    for (int k = 1; k < 5; k++) expect_grant($sformatf("rr%0d", k), 3);
    bus.req = 4'b0;
    @(negedge clk); @(negedge clk);
    chk("rr_idle", 32'(bus.busy), 32'd0);

    // 4: aborted request leaves pointer and register untouched
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1;
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = 4'b0000;
    #1;
    chk("abort_gnt", 32'(bus.gnt), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    chk("abort_q", 32'(bus.q), 32'h0);
    chk("abort_vld", 32'(bus.q_valid), 32'd0);
    set_wd(0, 8'h3C); set_wd(3, 8'h33);
    bus.req = 4'b1001;
    push(0, 8'h3C);
    expect_grant("after_abort", 1);

    // 5: reset lands in HOLD
    reset_n = 1'b0; bus.req = 4'b0;
    @(negedge clk);
    chk("hrst_q", 32'(bus.q), 32'h0);
    chk("hrst_vld", 32'(bus.q_valid), 32'd0);
    chk("hrst_busy", 32'(bus.busy), 32'd0);
    chk("hrst_own", 32'(bus.q_owner), 32'd0);
    reset_n = 1'b1; set_wd(0, 8'h77); bus.req = 4'hF;
    push(0, 8'h77);
    expect_grant("post_reset", 1);
    bus.req = 4'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);

    // 6: zero-hold instance, grant every other cycle
    for (int k = 0; k < 4; k++) push(k, d0[k]);
    bus0.req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e = sb.pop_front();
      @(negedge clk);
      chk($sformatf("h0_gnt%0d", k), 32'(bus0.gnt), 32'(one << e.idx));
      @(negedge clk);
      chk($sformatf("h0_pulse%0d", k), 32'(bus0.gnt), 32'd0);
      chk($sformatf("h0_q%0d", k), 32'(bus0.q), 32'(e.data));
      chk($sformatf("h0_own%0d", k), 32'(bus0.q_owner), 32'(e.idx));
      chk($sformatf("h0_busy%0d", k), 32'(bus0.busy), 32'd0);
    end
    bus0.req = 4'b0;
    @(negedge clk); @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
